// File: rtl/pipe_ex.sv
// pipe_ex: execute stage with ALU, single-outstanding load/store unit and valid/ready handshakes.
// Optional feature macro EX_WB_BYPASS_EN adds the wb_req_i snoop port for operand forwarding.
package liang_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] ele_t;

    typedef enum logic [3:0] {
        FU_ADD   = 4'd0,
        FU_SUB   = 4'd1,
        FU_AND   = 4'd2,
        FU_OR    = 4'd3,
        FU_XOR   = 4'd4,
        FU_SLL   = 4'd5,
        FU_SRL   = 4'd6,
        FU_SRA   = 4'd7,
        FU_SLT   = 4'd8,
        FU_SLTU  = 4'd9,
        FU_LOAD  = 4'd10,
        FU_STORE = 4'd11
    } fu_op_t;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef struct packed {
        pc_t       pc;
        fu_op_t    fu_op;
        logic      use_imm;
        mem_size_t mem_size;
        logic      mem_signed;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic      rd_wen;
        logic      ebreak;
    } uop_info_t;

    typedef struct packed {
        uop_info_t uop_info;
        ele_t      rs1_data;
        ele_t      rs2_data;
        ele_t      imm;
    } idToEx_t;

    typedef struct packed {
        uop_info_t uop_info;
        ele_t      alu_res;
        ele_t      lsu_res;
    } exToWb_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       rd_wen;
        ele_t       rd_wdata;
    } wb_req_t;

endpackage

module pipe_ex
    import liang_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  idToEx_t     idToEx_i,
    input  logic        id_valid_i,
    output logic        ex_ready_o,
    output exToWb_t     exToWb_o,
    output logic        ex_valid_o,
    input  logic        wb_ready_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_wen_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_rsp_valid_i,
`ifdef EX_WB_BYPASS_EN
    input  wb_req_t     wb_req_i,
`endif
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_REQ  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_OUT      = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       ex_valid_q, ex_valid_d;
    logic       mem_req_valid_q, mem_req_valid_d;
    uop_info_t  uop_q, uop_d;
    ele_t       alu_res_q, alu_res_d;
    ele_t       lsu_res_q, lsu_res_d;
    ele_t       addr_q, addr_d;
    ele_t       wdata_q, wdata_d;
    logic [3:0] wmask_q, wmask_d;
    logic       wen_q, wen_d;

    ele_t       op1;
    ele_t       rs2_val;
    ele_t       op2;
    ele_t       alu_out;
    ele_t       addr_calc;
    ele_t       wdata_rep;
    logic [3:0] wmask_calc;
    ele_t       lane_sh;
    ele_t       load_val;
    logic       accept;
    logic       is_mem;

    function automatic ele_t alu(input fu_op_t op, input ele_t a, input ele_t b);
        ele_t r;
        case (op)
            FU_ADD:  r = a + b;
            FU_SUB:  r = a - b;
            FU_AND:  r = a & b;
            FU_OR:   r = a | b;
            FU_XOR:  r = a ^ b;
            FU_SLL:  r = a << b[4:0];
            FU_SRL:  r = a >> b[4:0];
            FU_SRA:  r = ele_t'($signed(a) >>> b[4:0]);
            FU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            FU_SLTU: r = {31'd0, a < b};
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign ex_ready_o = (state_q == S_IDLE) || ((state_q == S_OUT) && wb_ready_i);
    assign accept     = id_valid_i && ex_ready_o;
    assign is_mem     = (idToEx_i.uop_info.fu_op == FU_LOAD) ||
                        (idToEx_i.uop_info.fu_op == FU_STORE);

    // Operand selection, with optional forwarding of the writeback-port value.
    always_comb begin
        op1     = idToEx_i.rs1_data;
        rs2_val = idToEx_i.rs2_data;
`ifdef EX_WB_BYPASS_EN
        if (wb_req_i.rd_wen && (wb_req_i.rd != 5'd0)) begin
            if (wb_req_i.rd == idToEx_i.uop_info.rs1) op1 = wb_req_i.rd_wdata;
            if (wb_req_i.rd == idToEx_i.uop_info.rs2) rs2_val = wb_req_i.rd_wdata;
        end
`endif
        op2       = idToEx_i.uop_info.use_imm ? idToEx_i.imm : rs2_val;
        alu_out   = alu(idToEx_i.uop_info.fu_op, op1, op2);
        addr_calc = op1 + idToEx_i.imm;
    end

    // Byte-lane mask and replicated write data for the store being accepted.
    always_comb begin
        case (idToEx_i.uop_info.mem_size)
            MEM_B: begin
                wmask_calc = 4'b0001 << addr_calc[1:0];
                wdata_rep  = {4{rs2_val[7:0]}};
            end
            MEM_H: begin
                wmask_calc = 4'b0011 << addr_calc[1:0];
                wdata_rep  = {2{rs2_val[15:0]}};
            end
            default: begin
                wmask_calc = 4'b1111;
                wdata_rep  = rs2_val;
            end
        endcase
    end

    // Load result: pick the addressed lane and extend it.
    always_comb begin
        lane_sh = mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (uop_q.mem_size)
            MEM_B:   load_val = {{24{uop_q.mem_signed & lane_sh[7]}}, lane_sh[7:0]};
            MEM_H:   load_val = {{16{uop_q.mem_signed & lane_sh[15]}}, lane_sh[15:0]};
            default: load_val = lane_sh;
        endcase
    end

    // Next-state and next-payload; an accept overrides whatever the state would do.
    always_comb begin
        state_d         = state_q;
        ex_valid_d      = ex_valid_q;
        mem_req_valid_d = mem_req_valid_q;
        uop_d           = uop_q;
        alu_res_d       = alu_res_q;
        lsu_res_d       = lsu_res_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        wen_d           = wen_q;
        case (state_q)
            S_IDLE: begin
            end
            S_MEM_REQ: begin
                if (mem_req_ready_i) begin
                    state_d         = S_MEM_WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            S_MEM_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d    = S_OUT;
                    ex_valid_d = 1'b1;
                    // Stores keep lsu_res at zero; only loads return data.
                    if (uop_q.fu_op == FU_LOAD) lsu_res_d = load_val;
                end
            end
            S_OUT: begin
                if (wb_ready_i) begin
                    state_d    = S_IDLE;
                    ex_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept) begin
            uop_d           = idToEx_i.uop_info;
            // Memory uops report their effective address as alu_res.
            alu_res_d       = is_mem ? addr_calc : alu_out;
            lsu_res_d       = '0;
            addr_d          = addr_calc;
            wdata_d         = wdata_rep;
            wmask_d         = wmask_calc;
            wen_d           = (idToEx_i.uop_info.fu_op == FU_STORE);
            state_d         = is_mem ? S_MEM_REQ : S_OUT;
            ex_valid_d      = !is_mem;
            mem_req_valid_d = is_mem;
        end
    end

    // Control state and registered valids; reset drops any in-flight uop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            ex_valid_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ex_valid_q      <= ex_valid_d;
            mem_req_valid_q <= mem_req_valid_d;
        end
    end

    // Payload registers; qualified by the valids so they carry no reset.
    always_ff @(posedge clk_i) begin
        uop_q     <= uop_d;
        alu_res_q <= alu_res_d;
        lsu_res_q <= lsu_res_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        wmask_q   <= wmask_d;
        wen_q     <= wen_d;
    end

    // Drive output bundles from the registered state.
    always_comb begin
        exToWb_o.uop_info = uop_q;
        exToWb_o.alu_res  = alu_res_q;
        exToWb_o.lsu_res  = lsu_res_q;
        ex_valid_o        = ex_valid_q;
        mem_req_valid_o   = mem_req_valid_q;
        mem_addr_o        = addr_q;
        mem_wdata_o       = wdata_q;
        mem_wmask_o       = wmask_q;
        mem_wen_o         = wen_q;
    end

endmodule

// File: doc/pipe_ex.md
PIPE_EX -- requirements
Module: pipe_ex

Interface
REQ-001 SHALL import liang_pkg::*; types pc_t, ele_t (32 bit), idToEx_t, exToWb_t, wb_req_t come from it.
REQ-002 clk_i  in  1  single clock; all state updates on posedge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 idToEx_i  in  idToEx_t  uop_info, rs1_data, rs2_data, imm from decode.
REQ-005 id_valid_i  in  1  idToEx_i valid.
REQ-006 ex_ready_o  out  1  block accepts a uop this cycle.
REQ-007 exToWb_o  out  exToWb_t  uop_info, alu_res, lsu_res to writeback.
REQ-008 ex_valid_o  out  1  exToWb_o valid.
REQ-009 wb_ready_i  in  1  writeback accepts exToWb_o.
REQ-010 mem_req_valid_o / mem_req_ready_i  out/in  1/1  memory request handshake.
REQ-011 mem_addr_o, mem_wdata_o  out  32 each; mem_wen_o out 1; mem_wmask_o out 4.
REQ-012 mem_rsp_valid_i  in  1; mem_rdata_i  in  32  load/store response (one per request).
REQ-013 wb_req_i  in  wb_req_t  writeback port snoop; present only with EX_WB_BYPASS_EN.

Function
REQ-014 States: IDLE, MEM_REQ, MEM_WAIT, OUT.
REQ-015 ex_ready_o = (state==IDLE) || (state==OUT && wb_ready_i).
REQ-016 Accept = id_valid_i && ex_ready_o; accepted uop_info, operands latched that edge.
REQ-017 Accept, fu_op not LOAD/STORE: alu_res registered, next state OUT (1-cycle latency).
REQ-018 ALU: op2 = uop_info.use_imm ? imm : rs2_data; ADD, SUB, AND, OR, XOR, SLL/SRL/SRA (shamt = op2[4:0]), SLT, SLTU; 32-bit wrap, no overflow flag.
REQ-019 Accept, fu_op LOAD/STORE: address = rs1_data + imm (mod 2^32), next state MEM_REQ.
REQ-020 MEM_REQ: mem_req_valid_o=1; addr/wdata/wmask/wen held stable until mem_req_ready_i; then MEM_WAIT.
REQ-021 Store: wmask from mem_size (byte/half/word) shifted by addr[1:0]; wdata replicated into lanes.
REQ-022 MEM_WAIT: on mem_rsp_valid_i, lsu_res = lane selected by addr[1:0], sign/zero-extended per mem_signed; then OUT.
REQ-023 mem_rsp_valid_i outside MEM_WAIT SHALL be ignored.
REQ-024 OUT: ex_valid_o=1, exToWb_o stable; wb_ready_i=1 leaves OUT -> IDLE, or same-cycle accept of new uop (back-to-back, no bubble).
REQ-025 ex_valid_o=0 in IDLE, MEM_REQ, MEM_WAIT; exactly one OUT beat per accepted uop.
REQ-026 ebreak and other non-memory uops SHALL take the ALU path unchanged.

Reset
REQ-027 rst_i asserted at any time, including mid-MEM_REQ/MEM_WAIT: state=IDLE, ex_valid_o=0, mem_req_valid_o=0, ex_ready_o=1 after release; in-flight uop discarded.
REQ-028 Data registers (exToWb_o payload, address) need no reset; outputs gated by valids.

Configuration
REQ-029 Macro EX_WB_BYPASS_EN defined: wb_req_i exists; at accept, if wb_req_i.rd_wen && rd!=0 && rd matches rs1/rs2, rd_wdata replaces that operand.
REQ-030 EX_WB_BYPASS_EN undefined: no wb_req_i port; operands used as received.

Verification
REQ-031 ADD rs1=5, imm=7, use_imm, wb_ready_i=1 -> ex_valid_o next cycle, alu_res=12; back-to-back SUB 3-5 -> alu_res=0xFFFFFFFE one cycle later.
REQ-032 LB rs1=0x100, imm=3, rdata=0x80000000, mem_ready held low 3 cycles -> addr stable 0x103, lsu_res=0xFFFFFF80.
REQ-033 SH rs2=0x1234ABCD addr 0x102 -> wmask=4'b1100, wdata[31:16]=0xABCD, mem_wen_o=1.
REQ-034 wb_ready_i low 4 cycles in OUT -> exToWb_o/ex_valid_o unchanged, ex_ready_o=0, no new accept.
REQ-035 rst_i pulsed in MEM_WAIT, then stray mem_rsp_valid_i -> ex_valid_o stays 0, state IDLE.
REQ-036 EX_WB_BYPASS_EN: wb_req_i rd=5 wdata=0x10, uop rs1=5 rs1_data=0, ADD imm 1 -> alu_res=0x11; rd=0 -> alu_res=1.
